// File: rtl/pow_5_arb_pkg.sv
// rtl/pow_5_arb_pkg.sv - shared types and constants for the fifth-power arbiter
//
// Purpose: scheduler state encoding, number of multiply steps per job and the
// default operand width, shared by the arbiter top and its datapath.
package pow_5_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } arb_state_e;

  // n is loaded as the first factor, so four more multiplies give n^5.
  localparam int POW_STEPS     = 4;
  localparam int DEFAULT_WIDTH = 18;

endpackage

// File: rtl/pow_5_iter_unit.sv
// rtl/pow_5_iter_unit.sv - iterative n^5 mod 2^WIDTH datapath
//
// Purpose: holds the operand, running product and step counter, and performs
// the multiply sequence after a start pulse.
// Ports:
//   clock   in   rising-edge clock
//   reset_n in   asynchronous active-low reset
//   start   in   load n and begin a new job (must only be pulsed when idle)
//   n       in   operand, sampled on start
//   done    out  high during the last step; result is valid in that cycle
//   result  out  running product times operand, i.e. n^5 when done is high
module pow_5_iter_unit
  import pow_5_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int STEP_W = $clog2(POW_STEPS);

  logic [WIDTH-1:0]  r_n_q, r_n_d;
  logic [WIDTH-1:0]  mul_q, mul_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              active_q, active_d;
  logic [WIDTH-1:0]  prod;

  // Truncation to WIDTH at every step keeps the final value n^5 mod 2^WIDTH.
  assign prod   = mul_q * r_n_q;
  assign done   = active_q && (step_q == STEP_W'(POW_STEPS - 1));
  // The product of the last step is handed out combinationally so the owner
  // can register it on the same edge that completes the fourth multiply.
  assign result = prod;

  always_comb begin
    r_n_d    = r_n_q;
    mul_d    = mul_q;
    step_d   = step_q;
    active_d = active_q;
    if (start) begin
      r_n_d    = n;
      mul_d    = n;
      step_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      mul_d = prod;
      if (done) begin
        step_d   = '0;
        active_d = 1'b0;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_n_q    <= '0;
      mul_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
    end else begin
      r_n_q    <= r_n_d;
      mul_q    <= mul_d;
      step_q   <= step_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/pow_5_arbiter.sv
// rtl/pow_5_arbiter.sv - round-robin scheduler sharing one fifth-power unit
//
// Purpose: grants one requester at a time to the iterative n^5 unit and
// broadcasts the tagged result.
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   level request per requester
//   n_flat   in   operands, requester i at [i*WIDTH +: WIDTH]
//   ack      out  one-hot one-cycle pulse, operand of that requester captured
//   busy     out  unit computing
//   ready    out  one-cycle pulse, result valid
//   ready_id out  index of the requester owning result
//   result   out  n^5 mod 2^WIDTH, held until the next completion
module pow_5_arbiter
  import pow_5_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] n_flat,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic                   ready,
  output logic [ID_W-1:0]        ready_id,
  output logic [WIDTH-1:0]       result
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [ID_W-1:0]   ready_id_q, ready_id_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic              found;
  logic [ID_W-1:0]   win;
  logic [WIDTH-1:0]  win_n;
  logic              start;
  logic              unit_done;
  logic [WIDTH-1:0]  unit_result;

  // Round-robin search: first asserted request at ptr, ptr+1, ... mod N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % N_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign win_n = n_flat[int'(win)*WIDTH +: WIDTH];
  assign start = (state_q == IDLE) && found;

  pow_5_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .n       (win_n),
    .done    (unit_done),
    .result  (unit_result)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    ack_d      = '0;
    busy_d     = busy_q;
    ready_d    = 1'b0;
    ready_id_d = ready_id_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d       = win;
          ack_d[win] = 1'b1;
          busy_d     = 1'b1;
          ptr_d      = ID_W'((int'(win) + 1) % N_REQ);
          state_d    = CALC;
        end
      end
      CALC: begin
        // Requests are ignored here; they are only sampled back in IDLE.
        if (unit_done) begin
          result_d   = unit_result;
          ready_id_d = id_q;
          ready_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      ready_id_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      ready_id_q <= ready_id_d;
      result_q   <= result_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign ready    = ready_q;
  assign ready_id = ready_id_q;
  assign result   = result_q;

endmodule
